tail_fsm_dwe: RTL
=================

# tail_fsm_dwe

Sequencing state machine for the tail-light turn-signal system. It samples the left/right turn requests and generates the one-hot state vector S0..S6. The existing `output_dwe` decoder consumes that vector and turns it into lamp outputs LA/LB/LC/RA/RB/RC. An internal prescaler sets the blink step rate, so states advance only on prescaler ticks.

## Interface
Parameters:
- DIV, default 4: clock cycles per sequence step; legal range 1..1024. Counter width is max(1, clog2(DIV)).

Ports:
- CLK  input  1  single system clock; all state changes occur on its rising edge.
- RESET  input  1  reset, asynchronous and active-high.
- L  input  1  left-turn request; synchronous to CLK; sampled only on tick cycles in S0.
- R  input  1  right-turn request; synchronous to CLK; sampled only on tick cycles in S0.
- S0  output  1  idle state (all lamps off).
- S1  output  1  left step 1 (decoder lights LA).
- S2  output  1  left step 2 (decoder lights LA, LB).
- S3  output  1  left step 3 (decoder lights LA, LB, LC).
- S4  output  1  right step 1 (decoder lights RA).
- S5  output  1  right step 2 (decoder lights RA, RB).
- S6  output  1  right step 3 (decoder lights RA, RB, RC).
- TICK  output  1  high for exactly one cycle, the cycle in which the prescaler count equals DIV-1.

## Operation
- State register: 7-bit one-hot; S0..S6 are driven directly from the register bits, with no output logic.
- Prescaler: free-running counter, incremented every CLK edge.
  - Wraps from DIV-1 to 0.
  - TICK = (count == DIV-1), combinational from the counter.
  - With DIV=1, TICK is constantly 1.
- State transitions occur only on an edge where TICK=1; otherwise the state holds.
- Transitions from S0:
  - L=1, R=0 -> S1.
  - R=1, L=0 -> S4.
  - L=R=0 or L=R=1 -> stay in S0 (conflicting requests are ignored).
- Left sequence: S1 -> S2 -> S3 -> S0, unconditionally. L and R are not examined during the sequence.
- Right sequence: S4 -> S5 -> S6 -> S0, unconditionally.
- A sequence always runs to completion, even if the request drops mid-sequence.
- With L held high, the left sequence repeats: S1, S2, S3, S0, S1, ...
  - S0 is always visited for one tick period between repeats; this is the off phase of the blink.
- Illegal state (register not exactly one-hot, including all zeros):
  - Next CLK edge loads S0, regardless of TICK.
  - The prescaler is unaffected.
- Reset: RESET=1 asynchronously forces S0=1, S1..S6=0, count=0 (so TICK=0 when DIV>1).
  - All outputs hold these values while RESET is high.
  - Reset mid-sequence abandons the sequence immediately.

## Timing
- TICK timing: after RESET deasserts, count reaches DIV-1 after DIV-1 edges, so TICK is high in the cycle before the DIV-th edge.
- First possible state change is the DIV-th rising edge after RESET deasserts; subsequent state changes fall on every DIV-th edge after that.
- Request latency: an L/R level present during a TICK cycle in S0 shows up as S1/S4 on that same edge. A request that is not high during any TICK cycle is never seen.
- Each non-idle state lasts exactly DIV cycles. One full sequence from S1 back to S0 takes 3*DIV cycles of lamp activity.
- Outputs are registered: glitch-free, and valid immediately after the clock edge.
- Illegal-state recovery: 1 cycle.
- Reset assertion takes effect with no clock edge needed. Deassertion follows the normal synchronous-release rule of the codebase.

## Test plan
- Async reset: assert RESET between clock edges with the FSM in S5 -> S0=1, S1..S6=0, TICK=0 before the next edge; state remains S0 through 3 edges while RESET is held.
- Left repeat: DIV=4, L=1, R=0 from reset release -> S1 at edge 4, S2 at edge 8, S3 at edge 12, S0 at edge 16, S1 at edge 20; TICK high in cycles 3, 7, 11, 15.
- Right single-shot with early drop: DIV=4, R=1 only during the first TICK cycle -> S4, S5, S6, S0 at edges 4, 8, 12, 16; remains S0 thereafter.
- Conflict and late-request handling:
  - L=R=1 for 5 tick periods -> S0 held throughout.
  - Then R=1 asserted while the FSM is in S2 -> left sequence completes to S0 first; S4 appears at the tick after S0 is reached.
- Illegal-state recovery: with DIV=8, force the register to 0000011 between edges and release -> next edge gives S0 only; prescaler count continues without reset.
- DIV=1: L=1 -> state advances every edge: S1, S2, S3, S0, S1; TICK constant 1.

Source files
------------

// File: rtl/tail_fsm_dwe.sv
// Turn-signal sequencer: one-hot S0..S6 state vector stepped by an internal prescaler tick.
// S1..S3 walk the left lamps, S4..S6 the right lamps, S0 is idle / blink off phase.
module tail_fsm_dwe #(
    parameter int unsigned DIV = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic L,
    input  logic R,
    output logic S0,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic S4,
    output logic S5,
    output logic S6,
    output logic TICK
);

    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [6:0] {
        ST_S0 = 7'b000_0001,
        ST_S1 = 7'b000_0010,
        ST_S2 = 7'b000_0100,
        ST_S3 = 7'b000_1000,
        ST_S4 = 7'b001_0000,
        ST_S5 = 7'b010_0000,
        ST_S6 = 7'b100_0000
    } state_e;

    // Raw vector rather than the enum type so non-one-hot values stay representable.
    logic [6:0]       state_q;
    logic [6:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end

    // Legal states advance only on tick; anything not one-hot falls back to idle at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_S0: begin
                if (tick) begin
                    if (L && !R) begin
                        state_d = ST_S1;
                    end else if (R && !L) begin
                        state_d = ST_S4;
                    end
                end
            end
            ST_S1:   if (tick) state_d = ST_S2;
            ST_S2:   if (tick) state_d = ST_S3;
            ST_S3:   if (tick) state_d = ST_S0;
            ST_S4:   if (tick) state_d = ST_S5;
            ST_S5:   if (tick) state_d = ST_S6;
            ST_S6:   if (tick) state_d = ST_S0;
            default: state_d = ST_S0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_S0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {S6, S5, S4, S3, S2, S1, S0} = state_q;
    assign TICK = tick;

endmodule
